// File: rtl/sonar_ranger_if.sv
// Signal bundle between the sonar ranging controller and its surroundings:
// sensor pins, mode-controller request lines and the result bus.
interface sonar_ranger_if #(
  parameter int CNT_W = 24
);
  logic             echo;
  logic             activate_sensor;
  logic             continuous;
  logic             trigger;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] echo_cycles;
  logic [3:0]       grid;
  logic [7:0]       grid_ascii;
  logic [2:0]       fsm_state;

  // valid is a one-cycle strobe with no ready/backpressure: the result fields
  // (timeout, echo_cycles, grid, grid_ascii) are stable from the valid cycle
  // until the next valid, so a consumer may sample them at any later time.
  modport master (
    output echo, activate_sensor, continuous,
    input  trigger, busy, valid, timeout, echo_cycles, grid, grid_ascii, fsm_state
  );

  modport slave (
    input  echo, activate_sensor, continuous,
    output trigger, busy, valid, timeout, echo_cycles, grid, grid_ascii, fsm_state
  );
endinterface

// File: rtl/sonar_ranger.sv
// HC-SR04 style ranging controller: trigger generation, echo synchronisation
// and timing, grid binning by repeated step counting, timeout detection.
module sonar_ranger #(
  parameter int CNT_W            = 24,
  parameter int TRIG_CYCLES      = 1000,
  parameter int ECHO_WAIT_CYCLES = 2_000_000,
  parameter int GRID_STEP        = 245_000,
  parameter int N_GRID           = 4,
  parameter int MAX_ECHO_CYCLES  = 2_500_000,
  parameter int PERIOD_CYCLES    = 10_000_000
) (
  input logic          clk,
  input logic          reset,
  sonar_ranger_if.slave bus
);

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(ECHO_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(GRID_STEP - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_ECHO_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [3:0]       N_GRID_L    = 4'(N_GRID);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIGGER   = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       echo_sync_q, echo_sync_d;
  logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] echo_cnt_q, echo_cnt_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [3:0]       grid_acc_q, grid_acc_d;
  logic             trigger_q, trigger_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] echo_cycles_q, echo_cycles_d;
  logic [3:0]       grid_q, grid_d;
  logic             echo_s;
  logic             start;
  logic             count;

  assign echo_s = echo_sync_q[1];

  always_comb begin
    state_d       = state_q;
    echo_sync_d   = {echo_sync_q[0], bus.echo};
    trig_cnt_d    = trig_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    echo_cnt_d    = echo_cnt_q;
    step_cnt_d    = step_cnt_q;
    grid_acc_d    = grid_acc_q;
    period_cnt_d  = (period_cnt_q == PERIOD_LAST) ? period_cnt_q : period_cnt_q + 1'b1;
    valid_d       = 1'b0;
    timeout_d     = timeout_q;
    echo_cycles_d = echo_cycles_q;
    grid_d        = grid_q;
    start         = 1'b0;
    count         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        period_cnt_d = '0;
        if (bus.activate_sensor) start = 1'b1;
      end
      ST_TRIGGER: begin
        trig_cnt_d = trig_cnt_q + 1'b1;
        if (trig_cnt_q == TRIG_LAST) begin
          state_d    = ST_WAIT_ECHO;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT_ECHO: begin
        // A level test, so an echo already high on entry counts as a rise and
        // its first synchronised cycle is included in the width.
        if (echo_s) begin
          state_d = ST_MEASURE;
          count   = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ST_HOLDOFF;
          valid_d       = 1'b1;
          timeout_d     = 1'b1;
          grid_d        = 4'd0;
          echo_cycles_d = echo_cnt_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!echo_s) begin
          state_d       = ST_HOLDOFF;
          valid_d       = 1'b1;
          timeout_d     = 1'b0;
          echo_cycles_d = echo_cnt_q;
          grid_d        = (grid_acc_q < N_GRID_L) ? grid_acc_q + 4'd1 : 4'd0;
        end else begin
          count = 1'b1;
          if (echo_cnt_q == MAX_LAST) begin
            state_d       = ST_HOLDOFF;
            valid_d       = 1'b1;
            timeout_d     = 1'b1;
            grid_d        = 4'd0;
            echo_cycles_d = echo_cnt_q + 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (period_cnt_q == PERIOD_LAST) begin
          if (bus.continuous && bus.activate_sensor) start = 1'b1;
          else                                       state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Grid binning without a divider: step_cnt wraps every GRID_STEP counted
    // cycles and each wrap advances the saturating cell accumulator.
    if (count) begin
      echo_cnt_d = echo_cnt_q + 1'b1;
      if (step_cnt_q == STEP_LAST) begin
        step_cnt_d = '0;
        if (grid_acc_q != N_GRID_L) grid_acc_d = grid_acc_q + 4'd1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end

    if (start) begin
      state_d      = ST_TRIGGER;
      trig_cnt_d   = '0;
      wait_cnt_d   = '0;
      echo_cnt_d   = '0;
      step_cnt_d   = '0;
      grid_acc_d   = '0;
      period_cnt_d = '0;
    end

    trigger_d = (state_d == ST_TRIGGER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      echo_sync_q   <= '0;
      trig_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      echo_cnt_q    <= '0;
      step_cnt_q    <= '0;
      period_cnt_q  <= '0;
      grid_acc_q    <= '0;
      trigger_q     <= 1'b0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      echo_cycles_q <= '0;
      grid_q        <= '0;
    end else begin
      state_q       <= state_d;
      echo_sync_q   <= echo_sync_d;
      trig_cnt_q    <= trig_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      echo_cnt_q    <= echo_cnt_d;
      step_cnt_q    <= step_cnt_d;
      period_cnt_q  <= period_cnt_d;
      grid_acc_q    <= grid_acc_d;
      trigger_q     <= trigger_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      echo_cycles_q <= echo_cycles_d;
      grid_q        <= grid_d;
    end
  end

  assign bus.trigger     = trigger_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.valid       = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.echo_cycles = echo_cycles_q;
  assign bus.grid        = grid_q;
  assign bus.grid_ascii  = 8'h30 + {4'h0, grid_q};
  assign bus.fsm_state   = state_q;

endmodule

// File: doc/sonar_ranger.md
# sonar_ranger

Parametrised ultrasonic ranging controller for the HC-SR04-style sonar on the line-follower robot. It generates the trigger pulse and synchronises and times the echo internally, with no external counters. It reports the raw echo width, a grid index and its ASCII digit, and distinguishes timeouts from valid hits. It sits between the top-level mode controller (`activate_sensor`) and the UART/decision logic that consumes `grid_ascii`.

## Interface
- `CNT_W`, 24: width of all internal counters and `echo_cycles`.
- `TRIG_CYCLES`, 1000: trigger high time in clk cycles (10 us at 100 MHz).
- `ECHO_WAIT_CYCLES`, 2_000_000: maximum wait for echo rise after trigger falls.
- `GRID_STEP`, 245_000: echo cycles per grid cell.
- `N_GRID`, 4: number of grid cells, 1..9.
- `MAX_ECHO_CYCLES`, 2_500_000: echo width treated as no return.
- `PERIOD_CYCLES`, 10_000_000: minimum spacing between trigger rising edges.

Ports:
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-high reset.
- `echo` in 1: raw sensor echo, asynchronous to `clk`.
- `activate_sensor` in 1: request a measurement, level-sensitive.
- `continuous` in 1: 1 = auto re-trigger every period while `activate_sensor` is high.
- `trigger` out 1: sensor trigger pulse.
- `busy` out 1: high in every state except IDLE.
- `valid` out 1: one-cycle pulse when the result outputs update.
- `timeout` out 1: registered; 1 = last result had no echo or an over-length echo.
- `echo_cycles` out CNT_W: registered echo high time of the last result.
- `grid` out 4: registered; 0 = no object, 1..N_GRID = cell.
- `grid_ascii` out 8: combinational, `8'h30 + grid`.

## Operation
- Echo is passed through a 2-flop synchroniser; only the synchronised `echo_s` is used.
- FSM states: IDLE, TRIGGER, WAIT_ECHO, MEASURE, HOLDOFF.
- IDLE -> TRIGGER when `activate_sensor` = 1. This clears `trig_cnt`, `echo_cnt`, `grid_acc` and `step_cnt`, and starts `period_cnt` at 0.
- TRIGGER: `trigger` = 1 and `trig_cnt` increments. Move to WAIT_ECHO when `trig_cnt` = TRIG_CYCLES-1.
- WAIT_ECHO: move to MEASURE on `echo_s` = 1. At ECHO_WAIT_CYCLES cycles without a rise, post a timeout result and go to HOLDOFF.
- MEASURE, each cycle with `echo_s` = 1:
  - `echo_cnt` increments and `step_cnt` increments.
  - When `step_cnt` = GRID_STEP-1, it wraps to 0 and `grid_acc` increments, saturating at N_GRID.
  - No divider is used.
- MEASURE ends on one of two events:
  - `echo_s` falls: post a hit result.
  - `echo_cnt` reaches MAX_ECHO_CYCLES: post a timeout result.
- Hit result:
  - `echo_cycles` = `echo_cnt`, `timeout` = 0.
  - `grid` = `grid_acc`+1 if `grid_acc` < N_GRID, otherwise 0 (out of range).
  - A width of exactly k*GRID_STEP maps to grid k+1.
- Timeout result: `timeout` = 1, `grid` = 0, `echo_cycles` = count reached.
- Every result posting asserts `valid` for exactly one cycle.
- HOLDOFF: wait until `period_cnt` = PERIOD_CYCLES-1, then:
  - if `continuous` and `activate_sensor` are both 1, go directly to TRIGGER with counters cleared;
  - otherwise go to IDLE.
- `period_cnt` runs from trigger start through HOLDOFF and saturates at PERIOD_CYCLES-1.
- Deasserting `activate_sensor` mid-measurement does not abort it; the measurement completes.

## Timing
- Reset values: `trigger` 0, `busy` 0, `valid` 0, `timeout` 0, `echo_cycles` 0, `grid` 0, `grid_ascii` 8'h30, state IDLE.
- `trigger` is forced low asynchronously by `reset`; a reset mid-operation discards any pending result.
- `trigger` rises 1 cycle after `activate_sensor` is sampled high in IDLE and stays high exactly TRIG_CYCLES cycles.
- Echo-to-FSM latency is 2 cycles on both edges, so measured width equals pulse width, ±1 cycle.
- `valid` is asserted in the cycle after the terminating event is detected. Result outputs hold their values until the next `valid`.
- Trigger rising edges in continuous mode are spaced exactly PERIOD_CYCLES apart.
- An echo already high when WAIT_ECHO is entered is treated as a rise in that same cycle.

## Test plan
Sim parameters: TRIG_CYCLES=10, ECHO_WAIT_CYCLES=50, GRID_STEP=100, N_GRID=4, MAX_ECHO_CYCLES=600, PERIOD_CYCLES=1000.
- Reset, then one `activate_sensor` pulse -> `trigger` high 10 cycles. Echo 250 cycles -> `valid` once, `echo_cycles`=250±1, `grid`=3, `grid_ascii`=8'h33, `timeout`=0.
- Echo widths 99, 100 and 399 -> `grid` 1, 2 and 4 respectively. Width 450 -> `grid` 0, `timeout` 0.
- No echo -> 50 cycles after trigger falls, `valid` pulses with `timeout`=1, `grid`=0. Echo stuck high -> `timeout`=1 at `echo_cycles`=600.
- `continuous`=1 with `activate_sensor` held -> trigger rising edges exactly 1000 cycles apart and one `valid` per period. Drop `activate_sensor` -> FSM returns to IDLE after the current period and `busy`=0.
- Assert `reset` mid-MEASURE -> `trigger`, `valid`, `grid`, `busy` go to reset values immediately, no `valid` afterwards, and the next activation measures correctly.
